cosim_commit_serializer: RTL and testbench

COSIM_COMMIT_SERIALIZER -- requirements
Module: cosim_commit_serializer

---
 rtl/cosim_commit_serializer.sv | 154 +++++++++++++++
 tb/tb_cosim_commit_serializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cosim_commit_serializer.sv
// ============================================================================
// cosim_commit_serializer : flattens per-cycle retire groups (plus an optional
//   trap record) into an in-order record FIFO for a co-simulation consumer.
//   Optional drop tracking is enabled by defining COSIM_SER_OVERFLOW_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cosim_commit_serializer #(
    parameter int COMMIT_WIDTH = 2,
    parameter int XLEN         = 64,
    parameter int INST_BITS    = 32,
    parameter int RD           = 5,
    parameter int DEPTH        = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [COMMIT_WIDTH-1:0]        in_valid,
    input  logic [XLEN*COMMIT_WIDTH-1:0]   in_pc,
    input  logic [INST_BITS*COMMIT_WIDTH-1:0] in_inst,
    input  logic [XLEN*COMMIT_WIDTH-1:0]   in_wdata,
    input  logic [COMMIT_WIDTH-1:0]        in_wdata_valid,
    input  logic [RD*COMMIT_WIDTH-1:0]     in_wdata_dest,
    input  logic                           int_xcpt,
    input  logic [XLEN-1:0]                cause,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_is_trap,
    output logic [XLEN-1:0]                out_pc,
    output logic [INST_BITS-1:0]           out_inst,
    output logic [XLEN-1:0]                out_wdata,
    output logic                           out_wdata_valid,
    output logic [RD-1:0]                  out_wdata_dest,
    output logic                           out_overflow,
    output logic [15:0]                    out_drop_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Record storage; never reset, occupancy is tracked purely by r_count.
    logic [XLEN-1:0]      r_mem_pc    [DEPTH];
    logic [INST_BITS-1:0] r_mem_inst  [DEPTH];
    logic [XLEN-1:0]      r_mem_wdata [DEPTH];
    logic                 r_mem_wv    [DEPTH];
    logic [RD-1:0]        r_mem_dest  [DEPTH];
    logic                 r_mem_trap  [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [PTR_W-1:0] w_lane_idx [COMMIT_WIDTH];
    logic [PTR_W-1:0] w_trap_idx;
    logic [CNT_W-1:0] w_pop;
    logic [CNT_W-1:0] w_n;
    logic [CNT_W-1:0] w_free;
    logic             w_accept;
    logic             w_deq;

    // Each valid lane lands at write pointer + number of valid lanes below it,
    // so the group is packed densely in ascending lane order.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_lane_idx[i] = r_wr_ptr + w_pop[PTR_W-1:0];
            w_pop         = w_pop + CNT_W'(in_valid[i]);
        end
        w_trap_idx = r_wr_ptr + w_pop[PTR_W-1:0];
        w_n        = w_pop + CNT_W'(int_xcpt);
    end

    // Free space uses the pre-dequeue count: a record leaving this cycle does
    // not make room for the group arriving in the same cycle.
    assign w_free   = CNT_W'(DEPTH) - r_count;
    assign w_accept = (w_n != '0) && (w_free >= w_n);
    assign w_deq    = (r_count != '0) && out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + w_n[PTR_W-1:0];
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + (w_accept ? w_n : '0) - CNT_W'(w_deq);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_accept) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (in_valid[i]) begin
                    r_mem_pc[w_lane_idx[i]]    <= in_pc[i*XLEN +: XLEN];
                    r_mem_inst[w_lane_idx[i]]  <= in_inst[i*INST_BITS +: INST_BITS];
                    r_mem_wdata[w_lane_idx[i]] <= in_wdata[i*XLEN +: XLEN];
                    r_mem_wv[w_lane_idx[i]]    <= in_wdata_valid[i];
                    r_mem_dest[w_lane_idx[i]]  <= in_wdata_dest[i*RD +: RD];
                    r_mem_trap[w_lane_idx[i]]  <= 1'b0;
                end
            end
            if (int_xcpt) begin
                r_mem_pc[w_trap_idx]    <= '0;
                r_mem_inst[w_trap_idx]  <= '0;
                r_mem_wdata[w_trap_idx] <= cause;
                r_mem_wv[w_trap_idx]    <= 1'b0;
                r_mem_dest[w_trap_idx]  <= '0;
                r_mem_trap[w_trap_idx]  <= 1'b1;
            end
        end
    end

    assign out_valid       = (r_count != '0);
    assign out_is_trap     = r_mem_trap[r_rd_ptr];
    assign out_pc          = r_mem_pc[r_rd_ptr];
    assign out_inst        = r_mem_inst[r_rd_ptr];
    assign out_wdata       = r_mem_wdata[r_rd_ptr];
    assign out_wdata_valid = r_mem_wv[r_rd_ptr];
    assign out_wdata_dest  = r_mem_dest[r_rd_ptr];

`ifdef COSIM_SER_OVERFLOW_EN
    logic        w_drop;
    logic        r_overflow;
    logic [15:0] r_drop_count;

    assign w_drop = (w_n != '0) && !w_accept;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign out_overflow   = r_overflow;
    assign out_drop_count = r_drop_count;
`else
    assign out_overflow   = 1'b0;
    assign out_drop_count = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cosim_commit_serializer.sv
// ============================================================================
// tb_cosim_commit_serializer : queue-model scoreboard bench for the serializer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cosim_commit_serializer;

    typedef struct packed {
        logic        trap;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] wdata;
        logic        wv;
        logic [4:0]  dest;
    } rec_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   in_valid = '0;
    logic [127:0] in_pc = '0;
    logic [63:0]  in_inst = '0;
    logic [127:0] in_wdata = '0;
    logic [1:0]   in_wdata_valid = '0;
    logic [9:0]   in_wdata_dest = '0;
    logic         int_xcpt = 1'b0;
    logic [63:0]  cause = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic         out_is_trap;
    logic [63:0]  out_pc;
    logic [31:0]  out_inst;
    logic [63:0]  out_wdata;
    logic         out_wdata_valid;
    logic [4:0]   out_wdata_dest;
    logic         out_overflow;
    logic [15:0]  out_drop_count;

    always #5 clock = ~clock;

    cosim_commit_serializer #(
        .COMMIT_WIDTH(2), .XLEN(64), .INST_BITS(32), .RD(5), .DEPTH(8)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_wdata(in_wdata), .in_wdata_valid(in_wdata_valid),
        .in_wdata_dest(in_wdata_dest), .int_xcpt(int_xcpt), .cause(cause),
        .out_valid(out_valid), .out_ready(out_ready), .out_is_trap(out_is_trap),
        .out_pc(out_pc), .out_inst(out_inst), .out_wdata(out_wdata),
        .out_wdata_valid(out_wdata_valid), .out_wdata_dest(out_wdata_dest),
        .out_overflow(out_overflow), .out_drop_count(out_drop_count)
    );

    // Reference model: exp_q mirrors what the DUT holds; pend_q holds the group
    // that the DUT will latch at the next rising edge.
    rec_t        exp_q[$];
    rec_t        pend_q[$];
    logic        pend_drop  = 1'b0;
    logic        pend_clear = 1'b0;
    logic        exp_ovf    = 1'b0;
    logic [15:0] exp_drops  = '0;
    logic        checking   = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic step(input logic [1:0] v, input logic [127:0] pc, input logic x,
                        input logic [63:0] c, input logic rdy, input logic rst);
        rec_t r;
        int   n;
        @(posedge clock);
        #1;
        if (pend_clear) begin
            exp_q.delete();
            exp_ovf   = 1'b0;
            exp_drops = '0;
            checking  = 1'b1;
        end else begin
            while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
            if (pend_drop) begin
                exp_ovf = 1'b1;
                if (exp_drops != 16'hFFFF) exp_drops = exp_drops + 16'd1;
            end
        end
        pend_q.delete();
        pend_drop  = 1'b0;
        pend_clear = rst;

        in_inst        = {$urandom, $urandom};
        in_wdata       = {$urandom, $urandom, $urandom, $urandom};
        in_wdata_valid = 2'($urandom);
        in_wdata_dest  = 10'($urandom);
        in_valid       = v;
        in_pc          = pc;
        int_xcpt       = x;
        cause          = c;
        out_ready      = rdy;
        reset          = rst;

        if (!rst) begin
            n = int'(v[0]) + int'(v[1]) + int'(x);
            if (n != 0) begin
                if (8 - exp_q.size() >= n) begin
                    for (int l = 0; l < 2; l++) begin
                        if (v[l]) begin
                            r.trap  = 1'b0;
                            r.pc    = pc[l*64 +: 64];
                            r.inst  = in_inst[l*32 +: 32];
                            r.wdata = in_wdata[l*64 +: 64];
                            r.wv    = in_wdata_valid[l];
                            r.dest  = in_wdata_dest[l*5 +: 5];
                            pend_q.push_back(r);
                        end
                    end
                    if (x) begin
                        r.trap  = 1'b1;
                        r.pc    = '0;
                        r.inst  = '0;
                        r.wdata = c;
                        r.wv    = 1'b0;
                        r.dest  = '0;
                        pend_q.push_back(r);
                    end
                end else begin
                    pend_drop = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input logic rdy);
        step(2'b00, '0, 1'b0, '0, rdy, 1'b0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: inputs settle 1 time unit after each rising edge, so the falling
    // edge sees stable outputs and the handshake about to happen.
    always @(negedge clock) begin
        rec_t act;
        if (checking) begin
            checks++;
            if (out_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL out_valid: got %b expected %b at %0t", out_valid,
                         (exp_q.size() != 0), $time);
            end
            if (out_valid === 1'b1 && exp_q.size() != 0) begin
                act = {out_is_trap, out_pc, out_inst, out_wdata, out_wdata_valid, out_wdata_dest};
                checks++;
                if (act !== exp_q[0]) begin
                    errors++;
                    $display("FAIL record: got %h expected %h at %0t", act, exp_q[0], $time);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
            checks++;
`ifdef COSIM_SER_OVERFLOW_EN
            if ({out_overflow, out_drop_count} !== {exp_ovf, exp_drops}) begin
                errors++;
                $display("FAIL overflow: got %b/%0d expected %b/%0d at %0t", out_overflow,
                         out_drop_count, exp_ovf, exp_drops, $time);
            end
`else
            if ({out_overflow, out_drop_count} !== 17'd0) begin
                errors++;
                $display("FAIL overflow: got %b/%0d expected 0/0 at %0t", out_overflow,
                         out_drop_count, $time);
            end
`endif
        end
    end

    initial begin
        step(2'b00, '0, 1'b0, '0, 1'b0, 1'b1);
        idle(1'b1);

        // Two-lane commit, consecutive output records.
        step(2'b11, {64'h8000_0004, 64'h8000_0000}, 1'b0, '0, 1'b1, 1'b0);
        repeat (4) idle(1'b1);

        // Upper lane only, followed by a trap record.
        step(2'b10, {64'h1000, 64'h0}, 1'b1, 64'h8000_0000_0000_0007, 1'b1, 1'b0);
        repeat (4) idle(1'b1);

        // Trap-only cycle.
        step(2'b00, rnd128(), 1'b1, 64'h0000_0000_0000_000B, 1'b1, 1'b0);
        repeat (3) idle(1'b1);

        // Fill to 8 with the consumer stalled; the fifth group is dropped.
        repeat (5) step(2'b11, rnd128(), 1'b0, '0, 1'b0, 1'b0);
        repeat (2) idle(1'b0);
        repeat (10) idle(1'b1);

        // Count 7: a pair is dropped whole, then a single with dequeue is accepted.
        repeat (3) step(2'b11, rnd128(), 1'b0, '0, 1'b0, 1'b0);
        step(2'b01, rnd128(), 1'b0, '0, 1'b0, 1'b0);
        step(2'b11, rnd128(), 1'b0, '0, 1'b0, 1'b0);
        step(2'b10, rnd128(), 1'b0, '0, 1'b1, 1'b0);
        step(2'b00, '0, 1'b1, 64'h5, 1'b0, 1'b0);
        repeat (12) idle(1'b1);

        // Random traffic across pointer wrap, with a reset mid-stream.
        for (int i = 0; i < 300; i++) begin
            step(2'($urandom), rnd128(), ($urandom_range(0, 5) == 0),
                 {$urandom, $urandom}, ($urandom_range(0, 9) < 6), (i == 150));
        end

        for (int k = 0; k < 40 && (exp_q.size() != 0 || pend_q.size() != 0); k++) begin
            idle(1'b1);
        end
        repeat (2) idle(1'b1);
        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
